// File: rtl/vga_pkg.sv
// Types and constants shared by the frame plotter and the VGA wrapper.
package vga_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StDraw,
        StDone
    } state_e;

    localparam logic [2:0] FG_DEFAULT = 3'b111;
    localparam logic [2:0] BG_DEFAULT = 3'b000;

    // Drawable area; the wrapper adds its margins around this.
    localparam int unsigned DRAW_WIDTH  = 128;
    localparam int unsigned DRAW_HEIGHT = 96;

endpackage

// File: rtl/pixel_serializer.sv
// Loadable 8-bit shift register that presents one pixel bit per cycle, MSB first,
// with a flag marking the eighth (last) bit of the byte.
module pixel_serializer (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_shift,
    output logic       o_bit,
    output logic       o_last
);

    logic [7:0] r_sr;
    logic [2:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sr  <= 8'd0;
            r_cnt <= 3'd0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_cnt <= 3'd0;
        end else if (i_shift) begin
            r_sr  <= {r_sr[6:0], 1'b0};
            r_cnt <= r_cnt + 3'd1;
        end
    end

    assign o_bit  = r_sr[7];
    assign o_last = (r_cnt == 3'd7);

endmodule

// File: rtl/vga_frame_plotter.sv
// Sweeps a 1bpp display memory row by row and emits one plot per cycle
// (x, y, colour, plot) for the VGA wrapper.
module vga_frame_plotter
    import vga_pkg::*;
#(
    parameter int unsigned WIDTH   = DRAW_WIDTH,
    parameter int unsigned HEIGHT  = DRAW_HEIGHT,
    parameter int unsigned MEM_LAT = 1,
    parameter logic [2:0]  FG      = FG_DEFAULT,
    parameter logic [2:0]  BG      = BG_DEFAULT,
    parameter int unsigned AW      = 11
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [7:0]    mem_data,
    output logic [7:0]    x,
    output logic [6:0]    y,
    output logic [2:0]    colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam int unsigned BYTES_PER_ROW = WIDTH / 8;
    localparam logic [4:0]  LAST_CB       = 5'(BYTES_PER_ROW - 1);
    localparam logic [6:0]  LAST_ROW      = 7'(HEIGHT - 1);
    localparam logic [7:0]  LAT_INIT      = 8'(MEM_LAT - 1);

    state_e        r_state, w_state_d;
    logic [4:0]    r_cb, w_cb_d, w_cb_next;
    logic [6:0]    r_row, w_row_d, w_row_next;
    logic [7:0]    r_lat, w_lat_d;
    logic          r_mem_rd, w_mem_rd_d;
    logic [AW-1:0] r_mem_addr, w_mem_addr_d, w_addr_next;
    logic [7:0]    r_x, w_x_d;
    logic [6:0]    r_y, w_y_d;
    logic          r_plot, w_plot_d;
    logic          r_busy, w_busy_d;
    logic          r_done, w_done_d;
    logic          w_load, w_shift, w_bit, w_last, w_last_byte;

    pixel_serializer u_serializer (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_load),
        .i_data (mem_data),
        .i_shift(w_shift),
        .o_bit  (w_bit),
        .o_last (w_last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= StIdle;
            r_cb       <= 5'd0;
            r_row      <= 7'd0;
            r_lat      <= 8'd0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_x        <= 8'd0;
            r_y        <= 7'd0;
            r_plot     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cb       <= w_cb_d;
            r_row      <= w_row_d;
            r_lat      <= w_lat_d;
            r_mem_rd   <= w_mem_rd_d;
            r_mem_addr <= w_mem_addr_d;
            r_x        <= w_x_d;
            r_y        <= w_y_d;
            r_plot     <= w_plot_d;
            r_busy     <= w_busy_d;
            r_done     <= w_done_d;
        end
    end

    always_comb begin
        w_state_d    = r_state;
        w_cb_d       = r_cb;
        w_row_d      = r_row;
        w_lat_d      = r_lat;
        w_mem_rd_d   = 1'b0;
        w_mem_addr_d = r_mem_addr;
        w_x_d        = r_x;
        w_y_d        = r_y;
        w_plot_d     = 1'b0;
        w_busy_d     = r_busy;
        w_done_d     = 1'b0;
        w_load       = 1'b0;
        w_shift      = 1'b0;

        w_cb_next   = (r_cb == LAST_CB) ? 5'd0 : r_cb + 5'd1;
        w_row_next  = (r_cb == LAST_CB) ? r_row + 7'd1 : r_row;
        w_last_byte = (r_cb == LAST_CB) && (r_row == LAST_ROW);
        w_addr_next = AW'(32'(w_row_next) * BYTES_PER_ROW + 32'(w_cb_next));

        // Outputs are registered, so each branch sets up what the next state shows.
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_d    = StFetch;
                    w_cb_d       = 5'd0;
                    w_row_d      = 7'd0;
                    w_mem_rd_d   = 1'b1;
                    w_mem_addr_d = '0;
                    w_busy_d     = 1'b1;
                end
            end
            StFetch: begin
                w_state_d = StWait;
                w_lat_d   = LAT_INIT;
            end
            StWait: begin
                if (r_lat == 8'd0) begin
                    w_state_d = StDraw;
                    w_load    = 1'b1;
                    w_plot_d  = 1'b1;
                    w_x_d     = {r_cb, 3'b000};
                    w_y_d     = r_row;
                end else begin
                    w_lat_d = r_lat - 8'd1;
                end
            end
            StDraw: begin
                if (!w_last) begin
                    w_shift  = 1'b1;
                    w_plot_d = 1'b1;
                    w_x_d    = r_x + 8'd1;
                end else begin
                    w_cb_d  = w_cb_next;
                    w_row_d = w_row_next;
                    if (w_last_byte) begin
                        w_state_d = StDone;
                        w_done_d  = 1'b1;
                        w_busy_d  = 1'b0;
                    end else begin
                        w_state_d    = StFetch;
                        w_mem_rd_d   = 1'b1;
                        w_mem_addr_d = w_addr_next;
                    end
                end
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign mem_rd   = r_mem_rd;
    assign mem_addr = r_mem_addr;
    assign x        = r_x;
    assign y        = r_y;
    assign colour   = w_bit ? FG : BG;
    assign plot     = r_plot;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_vga_frame_plotter.sv
// Directed bench: default 128x96 plotter plus a small 16x2, MEM_LAT=3 instance.
module tb_vga_frame_plotter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start_s;

    // Default instance
    logic        mem_rd;
    logic [10:0] mem_addr;
    logic [7:0]  mem_data;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot, busy, done;
    logic [7:0]  mem [0:2047];

    // Small instance
    logic        s_rd;
    logic [1:0]  s_addr;
    logic [7:0]  s_data, s_p1, s_p2;
    logic [7:0]  s_x;
    logic [6:0]  s_y;
    logic [2:0]  s_colour;
    logic        s_plot, s_busy, s_done;
    logic [7:0]  mem_s [0:3];

    bit seen [0:12287];

    int n_tests = 0;
    int n_fail  = 0;

    vga_frame_plotter dut (
        .clock   (clk),
        .reset   (rst),
        .start   (start),
        .mem_rd  (mem_rd),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .x       (x),
        .y       (y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    vga_frame_plotter #(
        .WIDTH  (16),
        .HEIGHT (2),
        .MEM_LAT(3),
        .AW     (2)
    ) dut_s (
        .clock   (clk),
        .reset   (rst),
        .start   (start_s),
        .mem_rd  (s_rd),
        .mem_addr(s_addr),
        .mem_data(s_data),
        .x       (s_x),
        .y       (s_y),
        .colour  (s_colour),
        .plot    (s_plot),
        .busy    (s_busy),
        .done    (s_done)
    );

    // Junk value outside the valid-data cycle exposes mistimed latching.
    always @(posedge clk) begin
        mem_data <= mem_rd ? mem[mem_addr] : 8'h3C;
        s_p1     <= s_rd ? mem_s[s_addr] : 8'h3C;
        s_p2     <= s_p1;
        s_data   <= s_p2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the negedge of cycle 1 (first cycle after start is accepted).
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input bit restarts, input string tag);
        int cyc, plots, dup, col_err, done_cnt, done_cyc, busy_err, seen_cnt;
        int last_x, last_y, rd_cnt, addr_err, rd_wide, idx, a;
        logic [7:0] bb;
        logic [2:0] expcol;
        logic prev_rd;
        plots = 0; dup = 0; col_err = 0; done_cnt = 0; done_cyc = 0; busy_err = 0;
        seen_cnt = 0; last_x = -1; last_y = -1; rd_cnt = 0; addr_err = 0; rd_wide = 0;
        prev_rd = 1'b0;
        for (int i = 0; i < 12288; i++) seen[i] = 1'b0;
        pulse_start();
        cyc = 1;
        while (cyc <= 15400) begin
            if (plot) begin
                plots++;
                if (x >= 128 || y >= 96) dup++;
                else begin
                    idx = int'(y) * 128 + int'(x);
                    if (seen[idx]) dup++;
                    else begin
                        seen[idx] = 1'b1;
                        seen_cnt++;
                    end
                    a = int'(y) * 16 + int'(x) / 8;
                    bb = mem[a];
                    expcol = bb[7 - (int'(x) % 8)] ? 3'b111 : 3'b000;
                    if (colour != expcol) col_err++;
                end
                last_x = int'(x);
                last_y = int'(y);
            end
            if (mem_rd) begin
                if (int'(mem_addr) != rd_cnt) addr_err++;
                if (prev_rd) rd_wide++;
                rd_cnt++;
            end
            prev_rd = mem_rd;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (busy) busy_err++;
            end else if (cyc < 15361 && !busy) begin
                busy_err++;
            end
            start = (restarts && (cyc == 500 || cyc == 5000));
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "_plots"}, plots, 12288);
        check({tag, "_distinct"}, seen_cnt, 12288);
        check({tag, "_dup"}, dup, 0);
        check({tag, "_colour_err"}, col_err, 0);
        check({tag, "_last_x"}, last_x, 127);
        check({tag, "_last_y"}, last_y, 95);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_done_cyc"}, done_cyc, 15361);
        check({tag, "_busy_err"}, busy_err, 0);
        check({tag, "_rd_cnt"}, rd_cnt, 1536);
        check({tag, "_addr_err"}, addr_err, 0);
        check({tag, "_rd_wide"}, rd_wide, 0);
    endtask

    initial begin
        logic [2:0] a5_col [0:7];
        int bad, cyc, plots, col_err, done_cnt, done_cyc, first_plot, rd_cnt, addr_err;
        int last_x, last_y, a;
        int rd_cyc [0:3];
        logic [7:0] bb;
        logic [2:0] expcol;

        a5_col = '{3'd7, 3'd0, 3'd7, 3'd0, 3'd0, 3'd7, 3'd0, 3'd7};
        for (int i = 0; i < 2048; i++) mem[i] = 8'(i);
        mem_s = '{8'h81, 8'h0F, 8'hF0, 8'h55};

        rst = 1'b1;
        start = 1'b0;
        start_s = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_plot", plot, 0);
        check("reset_busy", busy, 0);
        rst = 1'b0;

        // Idle with no start
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (plot || busy || done || mem_rd) bad++;
            if (x != 8'd0 || y != 7'd0) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_colour", colour, 0);
        check("idle_addr", mem_addr, 0);

        // First byte 0xA5
        mem[0] = 8'hA5;
        pulse_start();
        check("a5_rd", mem_rd, 1);
        check("a5_addr", mem_addr, 0);
        check("a5_busy", busy, 1);
        check("a5_plot_c1", plot, 0);
        @(negedge clk);
        check("a5_rd_width", mem_rd, 0);
        check("a5_plot_c2", plot, 0);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            check("a5_plot", plot, 1);
            check("a5_x", x, b);
            check("a5_y", y, 0);
            check("a5_colour", colour, a5_col[b]);
        end
        @(negedge clk);
        check("a5_plot_c11", plot, 0);
        check("a5_rd2", mem_rd, 1);
        check("a5_addr2", mem_addr, 1);
        check("a5_x_hold", x, 7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem[0] = 8'h00;

        run_frame(1'b0, "frame");
        run_frame(1'b1, "restart");

        // Reset in DRAW at cycle 777: byte 77 (row 4, cb 13), bit 4 -> x=108
        pulse_start();
        cyc = 1;
        while (cyc < 777) begin
            @(negedge clk);
            cyc++;
        end
        check("mid_plot", plot, 1);
        check("mid_x", x, 108);
        check("mid_y", y, 4);
        rst = 1'b1;
        @(negedge clk);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || plot) bad++;
        end
        check("rst_quiet", bad, 0);
        pulse_start();
        check("redo_rd", mem_rd, 1);
        check("redo_addr", mem_addr, 0);
        @(negedge clk);
        @(negedge clk);
        check("redo_plot", plot, 1);
        check("redo_x", x, 0);
        check("redo_y", y, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Small instance: 4 bytes x 12 cycles + DONE
        plots = 0; col_err = 0; done_cnt = 0; done_cyc = 0; first_plot = 0;
        rd_cnt = 0; addr_err = 0; last_x = -1; last_y = -1;
        for (int i = 0; i < 4; i++) rd_cyc[i] = 0;
        @(negedge clk);
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (s_rd) begin
                if (rd_cnt < 4) rd_cyc[rd_cnt] = c;
                if (int'(s_addr) != rd_cnt) addr_err++;
                rd_cnt++;
            end
            if (s_plot) begin
                if (plots == 0) first_plot = c;
                plots++;
                a = int'(s_y) * 2 + int'(s_x) / 8;
                bb = mem_s[a];
                expcol = bb[7 - (int'(s_x) % 8)] ? 3'b111 : 3'b000;
                if (s_colour != expcol) col_err++;
                last_x = int'(s_x);
                last_y = int'(s_y);
            end
            if (s_done) begin
                done_cnt++;
                done_cyc = c;
            end
            @(negedge clk);
        end
        check("small_rd0_cyc", rd_cyc[0], 1);
        check("small_rd1_cyc", rd_cyc[1], 13);
        check("small_rd_cnt", rd_cnt, 4);
        check("small_addr_err", addr_err, 0);
        check("small_first_plot", first_plot, 5);
        check("small_plots", plots, 32);
        check("small_colour_err", col_err, 0);
        check("small_last_x", last_x, 15);
        check("small_last_y", last_y, 1);
        check("small_done_cnt", done_cnt, 1);
        check("small_done_cyc", done_cyc, 49);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_frame_plotter.md
Name: vga_frame_plotter

Overview:
- Upstream feeder for the VGA wrapper stage.
- On a start request, sweeps a 1-bit-per-pixel display memory (CPU-visible video RAM) row by row.
- Expands each byte into 8 pixels and emits one plot per cycle as (x, y, colour, plot), driving the wrapper's inputs directly.
- Coordinates are drawable-area relative; the wrapper adds the screen margins.

Parameters:
- WIDTH, 128, pixels per row; must be a multiple of 8 and at most 256.
- HEIGHT, 96, rows; at most 128.
- MEM_LAT, 1, read latency of the display memory in cycles; must be at least 1.
- FG, 3'b111, colour for a pixel bit of 1.
- BG, 3'b000, colour for a pixel bit of 0.
- AW, 11, address width; must satisfy 2^AW >= WIDTH*HEIGHT/8.

Ports:
- clock  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  request a full-frame redraw; sampled in IDLE only
- mem_rd  out  1  display-memory read strobe, one cycle per byte
- mem_addr  out  AW  byte address, y*(WIDTH/8) + x/8
- mem_data  in  8  read data, valid MEM_LAT cycles after mem_rd; bit 7 is the leftmost pixel
- x  out  8  pixel column for the wrapper
- y  out  7  pixel row for the wrapper
- colour  out  3  pixel colour for the wrapper
- plot  out  1  pixel write enable, one pixel per asserted cycle
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at frame completion

Behaviour:
- Clock and reset:
  - One clock (clock).
  - Reset is synchronous and active-high (reset).
  - While reset is high at a rising edge: state=IDLE; mem_rd, plot, busy and done are 0; x, y, colour and mem_addr are 0.
  - Reset mid-frame abandons the frame with no done pulse. The next frame starts from pixel (0,0).
- Outputs: all registered; no combinational path from any input to any output.
- States and transitions:
  - IDLE: if start=1, clear the column-byte counter cb and row counter r, then go to FETCH.
  - FETCH (1 cycle):
    - mem_rd=1, mem_addr = r*(WIDTH/8) + cb.
    - busy=1.
    - Go to WAIT.
  - WAIT (MEM_LAT cycles):
    - A latency counter counts down.
    - On the cycle mem_data is valid, latch it into an 8-bit shift register.
    - Go to DRAW.
  - DRAW (8 cycles, bit index b=0..7):
    - plot=1, x = cb*8 + b, y = r.
    - colour = FG if shift-register bit (7-b) is 1, else BG.
    - After b=7: if cb=WIDTH/8-1, set cb=0 and r=r+1, otherwise cb=cb+1.
    - If the byte just drawn was the last byte (cb=WIDTH/8-1 and r=HEIGHT-1), go to DONE; otherwise go to FETCH.
  - DONE (1 cycle): done=1, busy=0, plot=0, then go to IDLE.
- Throughput:
  - 1+MEM_LAT+8 cycles per byte.
  - Frame length = WIDTH*HEIGHT/8 * (9+MEM_LAT) cycles, plus 1 cycle for DONE.
  - Defaults: 1536 bytes × 10 cycles = 15360 cycles, plus 1.
- Signal rules:
  - plot is 0 outside DRAW.
  - x, y and colour hold their last values when plot=0.
  - mem_rd is exactly 1 cycle wide.
- start handling:
  - start while busy is ignored; it is not queued.
  - start held high continuously restarts a new frame the cycle after DONE.
- Arithmetic:
  - Compute x in 8 bits; no overflow for legal WIDTH values.
  - r wraps only via frame completion.
  - Address arithmetic is unsigned, truncated to AW bits.
- Simultaneous events: reset has priority over start and over every state transition.

Decomposition:
- Shared package vga_pkg:
  - State enum (IDLE, FETCH, WAIT, DRAW, DONE).
  - Default FG and BG colour constants.
  - Drawable-area constants WIDTH and HEIGHT, shared with the wrapper's margin offsets.
- Sub-module pixel_serializer:
  - Loadable 8-bit shift register plus 3-bit bit counter.
  - Outputs the current bit and a last-bit flag.
- FSM and address generation stay in vga_frame_plotter.

Test Plan:
- Reset released, no start -> plot, busy, done and mem_rd stay 0 for 100 cycles; x=0, y=0.
- Memory filled with 0xA5 at address 0, start pulsed 1 cycle (MEM_LAT=1):
  - mem_rd at cycle 1 with addr 0.
  - plot cycles 3–10 with x=0..7, y=0.
  - colour sequence FG, BG, FG, BG, BG, FG, BG, FG.
- Full frame with defaults and memory = address LSBs:
  - Exactly 12288 plot pulses; each (x,y) pair seen exactly once.
  - Last plot is x=127, y=95.
  - done pulses once, 15361 cycles after start is accepted.
  - busy falls with done.
- start re-pulsed at cycles 500 and 5000 mid-frame -> ignored; frame length and plot count unchanged.
- reset asserted in DRAW at cycle 777:
  - Next cycle: plot=0, busy=0, no done.
  - A subsequent start redraws from x=0, y=0, addr 0.
- MEM_LAT=3, WIDTH=16, HEIGHT=2:
  - 12 cycles per byte; data latched on the third cycle after mem_rd.
  - 32 plots total; done after 49 cycles.
